inst_fetch_resp: RTL and testbench
==================================

INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set the word count to 2**DEPTH_LOG2 (1024 words).
REQ-002 Parameter WAIT_CYCLES, default 0, range 0..15, SHALL set the extra response wait states.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-004 rst  in  1  SHALL be a synchronous, active-low reset.
REQ-005 ce  in  1  SHALL be the fetch enable from the PC stage (1 = ChipEnable).
REQ-006 addr  in  32  SHALL be the byte address of the requested instruction.
REQ-007 inst  out  32  SHALL be the fetched instruction word.
REQ-008 inst_valid  out  1  SHALL be a one-cycle pulse per completed response.
REQ-009 stall_req  out  1  SHALL request that the PC stage hold while a wait-stated fetch is in progress.
REQ-010 misalign  out  1  SHALL flag a response to an address with addr[1:0] != 0.
REQ-011 ld_we  in  1  SHALL enable a program-load write.
REQ-012 ld_addr  in  32  SHALL be the program-load byte address.
REQ-013 ld_data  in  32  SHALL be the program-load data.

Function
REQ-014 Word index SHALL be addr[DEPTH_LOG2+1:2], with higher bits ignored, so addresses wrap modulo the depth; the same rule applies to ld_addr.
REQ-015 States SHALL be IDLE and BUSY.
REQ-016 A request SHALL be accepted at a posedge in IDLE with ce=1, which latches addr.
REQ-017 With WAIT_CYCLES=0:
  - the block stays in IDLE;
  - inst and inst_valid are registered at the edge after acceptance (1-cycle latency);
  - one request per cycle is accepted back-to-back;
  - stall_req is never asserted.
REQ-018 With WAIT_CYCLES=W>0:
  - acceptance enters BUSY with counter=W;
  - the counter decrements each edge in BUSY;
  - at the edge where the counter is 0, inst and inst_valid are registered and the state returns to IDLE;
  - response edge = acceptance edge + W+1.
REQ-019 stall_req SHALL equal 1 exactly while in BUSY.
REQ-020 ce=0 in IDLE SHALL register inst=0 and inst_valid=0.
REQ-021 ce falling to 0 during BUSY SHALL abort the fetch: return to IDLE, inst=0, no inst_valid pulse.
REQ-022 Between responses, inst SHALL hold its last value unless REQ-020 or REQ-021 clears it.
REQ-023 The array SHALL be read at the response edge.
REQ-024 ld_we writing the same word at that same edge SHALL return the old data (read-before-write).
REQ-025 ld_we SHALL be honoured in any state, independent of ce.

Reset
REQ-026 rst=0 at a posedge SHALL force IDLE, counter=0, inst=0, inst_valid=0, stall_req=0, misalign=0, and discard any in-flight fetch.
REQ-027 Array contents SHALL be unaffected by reset.
REQ-028 A request with ce=1 at the first edge after rst returns to 1 SHALL be accepted.

Configuration
REQ-029 With macro INST_FETCH_ALIGN_CHK_EN defined, a misaligned request's response SHALL carry inst=0, misalign=1 and inst_valid=1.
REQ-030 Without INST_FETCH_ALIGN_CHK_EN, addr[1:0] SHALL be ignored and misalign SHALL be tied to 0.
REQ-031 The misalign port SHALL exist in both builds.

Structure
REQ-032 The shared defines SHALL hold InstAddrBus, InstBus, ZeroWord, ChipEnable/ChipDisable, RstEnable (active-low value) and the IDLE/BUSY state encodings.
REQ-033 The storage SHALL be a sub-module inst_mem_array: 1 write port, 1 synchronous read port, parameterised by DEPTH_LOG2.

Verification
REQ-034 Scenario 1 (W=0): load word 1 = 0x3401_1100; ce=1, addr=0x4 at edge k -> at edge k+1, inst=0x3401_1100 and inst_valid=1.
REQ-035 Scenario 2 (W=0): addresses 0x0, 0x4, 0x8 on consecutive edges -> three consecutive valid responses in order, stall_req=0 throughout.
REQ-036 Scenario 3 (W=3): request at edge k -> stall_req=1 for cycles k+1..k+4, response at edge k+4, then IDLE.
REQ-037 Scenario 4 (W=3): ce dropped at edge k+2 -> no inst_valid, inst=0, stall_req=0 from edge k+2.
REQ-038 Scenario 5: addr=0x1002 with INST_FETCH_ALIGN_CHK_EN -> inst=0, misalign=1; same stimulus without the macro -> contents of word 0x400 mod depth (word 0 for depth 1024), misalign=0.
REQ-039 Scenario 6: rst=0 asserted mid-BUSY -> IDLE, all outputs 0 at the next edge; a write to the fetched word at the response edge returns the old data.

Source files
------------

// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction fetch response block: bus widths,
// enable/reset encodings and the fetch FSM state type.
package inst_fetch_resp_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int CntWidth    = 4;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RstEnable   = 1'b0;  // reset is active low

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return byte_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_resp_mem.sv
// Instruction storage: one write port for program load, one synchronous read
// port. A same-edge write to the word being read returns the previous contents.
module inst_mem_array
  import inst_fetch_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int Depth = 1 << DEPTH_LOG2;

  logic [InstBus-1:0] mem [Depth];
  logic [InstBus-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction fetch response stage with optional wait states and program load.
// Build option INST_FETCH_ALIGN_CHK_EN turns misaligned fetches into zero/misalign responses.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall_req,
  output logic        misalign,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam logic [CntWidth-1:0] WaitLoad = CntWidth'(WAIT_CYCLES);
  localparam bit                  NoWait   = (WAIT_CYCLES == 0);

  fetch_state_e          state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic                  zero_q, zero_d;
  logic                  mis_q;
  logic                  accept;
  logic                  respond;
  logic                  rd_en;
  logic [InstBus-1:0]    mem_rdata;
  logic                  unused_addr_bits;

  assign accept = (state_q == IDLE) && (ce == ChipEnable);

`ifdef INST_FETCH_ALIGN_CHK_EN
  logic mis_d;
  logic misalign_q, misalign_d;

  always_comb begin
    mis_d      = accept ? is_misaligned(addr[1:0]) : mis_q;
    misalign_d = respond & mis_q;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      mis_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      mis_q      <= mis_d;
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign mis_q    = 1'b0;
  assign misalign = 1'b0;
`endif

  // With no wait states the response is tracked by pend_q while staying in IDLE,
  // so a new request can be accepted on the same edge a response is produced.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = 1'b0;
    valid_d = 1'b0;
    zero_d  = zero_q;
    respond = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          respond = 1'b1;
        end else if (ce == ChipDisable) begin
          zero_d = 1'b1;
        end
        if (accept) begin
          idx_d = addr[DEPTH_LOG2+1:2];
          if (NoWait) begin
            pend_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = WaitLoad;
          end
        end
      end
      BUSY: begin
        if (ce == ChipDisable) begin
          state_d = IDLE;
          cnt_d   = '0;
          zero_d  = 1'b1;
        end else if (cnt_q == '0) begin
          respond = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (respond) begin
      valid_d = 1'b1;
      zero_d  = mis_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  // The read register only loads on a real response, so it also holds inst between responses.
  assign rd_en = respond & ~mis_q;

  inst_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_inst_mem_array (
    .clk  (clk),
    .we   (ld_we),
    .waddr(ld_addr[DEPTH_LOG2+1:2]),
    .wdata(ld_data),
    .re   (rd_en),
    .raddr(idx_q),
    .rdata(mem_rdata)
  );

  assign inst       = zero_q ? ZeroWord : mem_rdata;
  assign inst_valid = valid_q;
  assign stall_req  = (state_q == BUSY);

  assign unused_addr_bits = ^{addr[InstAddrBus-1:DEPTH_LOG2+2], addr[1:0],
                              ld_addr[InstAddrBus-1:DEPTH_LOG2+2], ld_addr[1:0]};

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp: one instance with no wait states and one
// with three, sharing reset and program-load inputs.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [31:0] ld_addr, ld_data;

  logic        a_ce, a_valid, a_stall, a_mis;
  logic [31:0] a_addr, a_inst;
  logic        b_ce, b_valid, b_stall, b_mis;
  logic [31:0] b_addr, b_inst;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_mem [1024];
  logic [32:0] exp_a_q [$];
  logic [32:0] exp_b_q [$];
  logic [32:0] e5;
  logic [31:0] old_w0;
  logic [31:0] s2_addr [3];

  inst_fetch_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst), .ce(a_ce), .addr(a_addr), .inst(a_inst),
    .inst_valid(a_valid), .stall_req(a_stall), .misalign(a_mis),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_fetch_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .ce(b_ce), .addr(b_addr), .inst(b_inst),
    .inst_valid(b_valid), .stall_req(b_stall), .misalign(b_mis),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we = 1'b0;
    model_mem[a[11:2]] = d;
  endtask

  function automatic logic [32:0] exp_for(input logic [31:0] a);
`ifdef INST_FETCH_ALIGN_CHK_EN
    if (a[1:0] != 2'b00) return {1'b1, 32'd0};
`endif
    return {1'b0, model_mem[a[11:2]]};
  endfunction

  always @(negedge clk) begin
    logic [32:0] e;
    if (a_valid === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        check_val("a_unexpected_valid", 32'(a_valid), 32'd0);
      end else begin
        e = exp_a_q.pop_front();
        $display("A resp: inst=0x%08h mis=%0b exp_inst=0x%08h exp_mis=%0b", a_inst, a_mis, e[31:0], e[32]);
        check_val("a_inst", a_inst, e[31:0]);
        check_val("a_misalign", 32'(a_mis), 32'(e[32]));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (b_valid === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        check_val("b_unexpected_valid", 32'(b_valid), 32'd0);
      end else begin
        e = exp_b_q.pop_front();
        $display("B resp: inst=0x%08h mis=%0b exp_inst=0x%08h exp_mis=%0b", b_inst, b_mis, e[31:0], e[32]);
        check_val("b_inst", b_inst, e[31:0]);
        check_val("b_misalign", 32'(b_mis), 32'(e[32]));
      end
    end
  end

  initial begin
    rst = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    a_ce = 1'b0; a_addr = '0; b_ce = 1'b0; b_addr = '0;
    s2_addr[0] = 32'h0; s2_addr[1] = 32'h4; s2_addr[2] = 32'h8;
    step();
    step();
    check_val("rst_a_inst",  a_inst, 32'd0);
    check_val("rst_a_valid", 32'(a_valid), 32'd0);
    check_val("rst_a_stall", 32'(a_stall), 32'd0);
    check_val("rst_a_mis",   32'(a_mis), 32'd0);
    check_val("rst_b_inst",  b_inst, 32'd0);
    check_val("rst_b_stall", 32'(b_stall), 32'd0);
    rst = 1'b1;

    load_word(32'h0, 32'hA5A5_0F0F);
    load_word(32'h4, 32'h3401_1100);
    for (int i = 2; i < 16; i++) begin
      load_word(32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101_0101);
    end

    // Scenario 1: single fetch, one-cycle latency
    a_ce = 1'b1; a_addr = 32'h4; exp_a_q.push_back(exp_for(32'h4));
    step();
    a_ce = 1'b0;
    check_val("s1_no_early_valid", 32'(a_valid), 32'd0);
    step();
    check_val("s1_valid", 32'(a_valid), 32'd1);
    check_val("s1_inst", a_inst, 32'h3401_1100);
    step();
    check_val("s1_idle_clear_inst", a_inst, 32'd0);
    check_val("s1_idle_no_valid", 32'(a_valid), 32'd0);

    // Scenario 2: back-to-back fetches
    for (int i = 0; i < 3; i++) begin
      a_ce = 1'b1; a_addr = s2_addr[i]; exp_a_q.push_back(exp_for(s2_addr[i]));
      step();
      check_val("s2_stall", 32'(a_stall), 32'd0);
      check_val("s2_valid", 32'(a_valid), 32'(i > 0));
    end
    a_ce = 1'b0;
    step();
    check_val("s2_last_valid", 32'(a_valid), 32'd1);
    check_val("s2_last_stall", 32'(a_stall), 32'd0);
    step();
    check_val("s2_drain_valid", 32'(a_valid), 32'd0);

    // Scenario 5: misaligned, wrapping address
    a_ce = 1'b1; a_addr = 32'h1002; e5 = exp_for(32'h1002); exp_a_q.push_back(e5);
    step();
    a_ce = 1'b0;
    step();
    check_val("s5_valid", 32'(a_valid), 32'd1);
    check_val("s5_inst", a_inst, e5[31:0]);
    check_val("s5_mis", 32'(a_mis), 32'(e5[32]));
    step();

    // Random aligned traffic with random high address bits
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      ra     = $urandom & 32'hFFFF_F03C;
      a_ce   = 1'($urandom_range(0, 1));
      a_addr = ra;
      if (a_ce) exp_a_q.push_back(exp_for(ra));
      step();
    end
    a_ce = 1'b0;
    step();
    step();

    // Scenario 3: wait-stated fetch, addr changes while busy must be ignored
    b_ce = 1'b1; b_addr = 32'h8; exp_b_q.push_back(exp_for(32'h8));
    step();
    b_addr = 32'h3C;
    for (int i = 0; i < 4; i++) begin
      check_val("s3_stall_busy", 32'(b_stall), 32'd1);
      check_val("s3_no_valid", 32'(b_valid), 32'd0);
      step();
    end
    check_val("s3_stall_done", 32'(b_stall), 32'd0);
    check_val("s3_valid", 32'(b_valid), 32'd1);
    check_val("s3_inst", b_inst, model_mem[2]);

    // Scenario 4: new request, then ce dropped two edges later aborts it
    b_addr = 32'hC;
    step();
    check_val("s4_stall", 32'(b_stall), 32'd1);
    check_val("s4_inst_hold", b_inst, model_mem[2]);
    step();
    b_ce = 1'b0;
    step();
    check_val("s4_abort_stall", 32'(b_stall), 32'd0);
    check_val("s4_abort_inst", b_inst, 32'd0);
    check_val("s4_abort_valid", 32'(b_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("s4_no_late_valid", 32'(b_valid), 32'd0);
    end

    // Scenario 6: reset mid-BUSY, then read-before-write at the response edge
    b_ce = 1'b1; b_addr = 32'h14; exp_b_q.push_back(exp_for(32'h14));
    repeat (5) step();
    check_val("s6_pre_inst", b_inst, model_mem[5]);
    b_addr = 32'h4;
    step();
    step();
    check_val("s6_busy", 32'(b_stall), 32'd1);
    rst = 1'b0;
    step();
    check_val("s6_rst_stall", 32'(b_stall), 32'd0);
    check_val("s6_rst_inst", b_inst, 32'd0);
    check_val("s6_rst_valid", 32'(b_valid), 32'd0);
    check_val("s6_rst_mis", 32'(b_mis), 32'd0);
    rst = 1'b1;
    b_addr = 32'h0; old_w0 = model_mem[0]; exp_b_q.push_back(exp_for(32'h0));
    step();
    check_val("s6_accept_after_rst", 32'(b_stall), 32'd1);
    step();
    step();
    step();
    ld_we = 1'b1; ld_addr = 32'h0; ld_data = 32'hDEAD_BEEF;
    step();
    ld_we = 1'b0; model_mem[0] = 32'hDEAD_BEEF;
    b_ce = 1'b0;
    check_val("s6_rbw_valid", 32'(b_valid), 32'd1);
    check_val("s6_rbw_old_data", b_inst, old_w0);
    step();

    a_ce = 1'b1; a_addr = 32'h0; exp_a_q.push_back(exp_for(32'h0));
    step();
    a_ce = 1'b0;
    step();
    check_val("s6_write_landed", a_inst, 32'hDEAD_BEEF);
    step();
    step();

    check_val("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    check_val("b_queue_empty", 32'(exp_b_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
